// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each access takes WAIT_CYCLES wait states, then holds its response until accepted.
module dmem_responder #(
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned Words   = 2 ** (DM_ADDRESS - 2);
  localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [3:0]            be_q;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  commit;

  logic [DATA_W-1:0]     mem [Words];

  logic                  cur_we;
  logic [DM_ADDRESS-1:0] cur_addr;
  logic [DATA_W-1:0]     cur_wdata;
  logic [3:0]            cur_be;
  logic                  cur_err;
  logic [DM_ADDRESS-3:0] cur_idx;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero wait states the commit happens on the acceptance edge, so use the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_err = (cur_addr[1:0] != 2'b00) | (cur_we & (cur_be == 4'b0000));
    cur_idx = cur_addr[DM_ADDRESS-1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = cur_err;
      rdata_d = (cur_err | cur_we) ? '0 : mem[cur_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Storage is never reset; rst gating keeps a reset-time edge from committing.
  always_ff @(posedge clk) begin
    if (commit && !rst && cur_we && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad = 0;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [8:0]  z_req_addr;
  logic [31:0] z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  always #5 clk = ~clk;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the 2-wait instance; hold = cycles of rsp_ready=0 once valid.
  task automatic txn(input string tag, input logic we, input logic [8:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    rsp_ready = (hold == 0);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the latched request must be used.
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd; req_be = ~be;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk({tag, "/latency"}, 32'(n), 32'd3);
    chk({tag, "/rdata"}, rsp_rdata, exp_rd);
    chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      // A request offered while busy must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h010; req_wdata = 32'hFFFF_FFFF;
      req_be = 4'hF;
      @(negedge clk);
      chk({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, "/valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst/rdata", rsp_rdata, 32'd0);
    chk("rst/err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    txn("wr_full", 1'b1, 9'h010, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0, 1'b0);
    txn("rd_full", 1'b0, 9'h010, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF, 1'b0);
    txn("wr_b0", 1'b1, 9'h010, 32'h0000_00AA, 4'b0001, 0, 32'h0, 1'b0);
    txn("rd_b0", 1'b0, 9'h010, 32'h0, 4'b0000, 0, 32'hDEAD_BEAA, 1'b0);
    txn("wr_hi", 1'b1, 9'h010, 32'h1234_0000, 4'b1100, 0, 32'h0, 1'b0);
    txn("rd_hi", 1'b0, 9'h010, 32'h0, 4'b0000, 0, 32'h1234_BEAA, 1'b0);
    txn("rd_misal", 1'b0, 9'h013, 32'h0, 4'b0000, 0, 32'h0, 1'b1);
    txn("wr_nobe", 1'b1, 9'h010, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, 1'b1);
    txn("rd_unchg", 1'b0, 9'h010, 32'h0, 4'b0000, 0, 32'h1234_BEAA, 1'b0);
    txn("wr_020", 1'b1, 9'h020, 32'h1111_1111, 4'b1111, 0, 32'h0, 1'b0);
    txn("rd_hold", 1'b0, 9'h010, 32'h0, 4'b0000, 5, 32'h1234_BEAA, 1'b0);

    // Reset while a write sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'h5555_5555;
    req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstwait/in_wait", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstwait/req_ready", 32'(req_ready), 32'd1);
    chk("rstwait/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstwait/rdata", rsp_rdata, 32'd0);
    chk("rstwait/err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn("rd_020", 1'b0, 9'h020, 32'h0, 4'b0000, 0, 32'h1111_1111, 1'b0);

    // Zero wait states: back-to-back with rsp_ready held high.
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 9'h040; z_req_wdata = 32'hCAFE_F00D;
    z_req_be = 4'hF;
    chk("z/ready0", 32'(z_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("z/wr_valid", 32'(z_rsp_valid), 32'd1);
    chk("z/wr_busy", 32'(z_req_ready), 32'd0);
    z_req_we = 1'b0;
    @(posedge clk); #1;
    chk("z/ready1", 32'(z_req_ready), 32'd1);
    chk("z/idle_valid", 32'(z_rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("z/rd_valid", 32'(z_rsp_valid), 32'd1);
    chk("z/rd_data", z_rsp_rdata, 32'hCAFE_F00D);
    chk("z/rd_err", 32'(z_rsp_err), 32'd0);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (z_req_valid && z_req_ready) acc++;
    end
    chk("z/rate", 32'(acc), 32'd4);
    z_req_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
